ps2_rx_fifo: RTL and testbench

PS2_RX_FIFO -- requirements
Module: ps2_rx_fifo

---
 rtl/ps2_rx_fifo.sv | 166 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: synchronise and filter the bus, decode 11-bit frames, queue bytes in a FWFT FIFO.
// Optional odd-parity enforcement at the stop bit is enabled by defining PS2_RX_PARITY_CHECK_EN.
module ps2_rx_fifo #(
  parameter int FILTER_LEN  = 4,
  parameter int TIMEOUT_CYC = 20000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          ps2_clk,
  input  logic                          ps2_data,
  input  logic                          rd_en,
  output logic [7:0]                    rd_data,
  output logic                          empty,
  output logic                          full,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  output logic                          frame_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  FILT_TC  = 4'(FILTER_LEN - 1);
  localparam logic [15:0] TMO_LOAD = 16'(TIMEOUT_CYC - 1);
  localparam logic [AW:0] DEPTH_C  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic        clk_s1, clk_s2, data_s1, data_s2;
  logic        filt_clk;
  logic [3:0]  filt_cnt;
  logic        ev, ev_data;

  state_t      state;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift;
  logic [15:0] tmo_cnt;
  logic        wr_req;
  logic        parity_ok;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic        do_rd, do_wr;

  // Synchronisers and glitch filter; ev is a one-cycle strobe on each filtered falling edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      data_s1  <= 1'b1;
      data_s2  <= 1'b1;
      filt_clk <= 1'b1;
      filt_cnt <= '0;
      ev       <= 1'b0;
      ev_data  <= 1'b1;
    end else begin
      clk_s1  <= ps2_clk;
      clk_s2  <= clk_s1;
      data_s1 <= ps2_data;
      data_s2 <= data_s1;
      ev      <= 1'b0;
      if (clk_s2 == filt_clk) begin
        filt_cnt <= '0;
      end else if (filt_cnt == FILT_TC) begin
        filt_clk <= clk_s2;
        filt_cnt <= '0;
        ev       <= filt_clk;
        ev_data  <= data_s2;
      end else begin
        filt_cnt <= filt_cnt + 4'd1;
      end
    end
  end

`ifdef PS2_RX_PARITY_CHECK_EN
  logic par_bit;
  assign parity_ok = ^{shift, par_bit};
`else
  assign parity_ok = 1'b1;
`endif

  // Frame decoder with timeout down-counter reloaded on every event and while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      shift     <= '0;
      tmo_cnt   <= TMO_LOAD;
      wr_req    <= 1'b0;
      frame_err <= 1'b0;
`ifdef PS2_RX_PARITY_CHECK_EN
      par_bit   <= 1'b0;
`endif
    end else begin
      wr_req    <= 1'b0;
      frame_err <= 1'b0;
      if (ev) begin
        tmo_cnt <= TMO_LOAD;
        case (state)
          IDLE: begin
            if (!ev_data) begin
              state   <= DATA;
              bit_cnt <= '0;
            end else begin
              frame_err <= 1'b1;
            end
          end
          DATA: begin
            shift   <= {ev_data, shift[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) state <= PARITY;
          end
          PARITY: begin
`ifdef PS2_RX_PARITY_CHECK_EN
            par_bit <= ev_data;
`endif
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            if (ev_data && parity_ok) wr_req <= 1'b1;
            else                      frame_err <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (state == IDLE) begin
        tmo_cnt <= TMO_LOAD;
      end else if (tmo_cnt == 16'd0) begin
        state     <= IDLE;
        frame_err <= 1'b1;
        tmo_cnt   <= TMO_LOAD;
      end else begin
        tmo_cnt <= tmo_cnt - 16'd1;
      end
    end
  end

  assign empty   = (count == '0);
  assign full    = (count == DEPTH_C);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_req && (!full || do_rd);
  assign rd_data = mem[rd_ptr];

  // shift cannot change the cycle after STOP (a new event needs a full filtered clock period), so it feeds the FIFO directly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= wr_req && full && !do_rd;
      if (do_wr) begin
        mem[wr_ptr] <= shift;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: bit-banged PS/2 frames with hand-computed expectations.
module tb_ps2_rx_fifo;
  localparam int FL   = 4;
  localparam int TMO  = 1000;
  localparam int DEP  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       rd_en = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, overflow, frame_err;
  logic [$clog2(DEP):0] count;

  int compared = 0;
  int mismatched = 0;
  int ferr_cnt = 0;
  int ovf_cnt = 0;
  int ferr_base, ovf_base;

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TMO), .FIFO_DEPTH(DEP)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .rd_en(rd_en),
    .rd_data(rd_data), .empty(empty), .full(full), .count(count),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) ferr_cnt++;
    if (overflow)  ovf_cnt++;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_neg(input int n);
    for (int k = 0; k < n; k++) @(negedge clk);
  endtask

  // Sends the first nbits of a frame; glitch_bit selects a bit whose high phase gets a FL-1 cycle low glitch.
  task automatic send_frame(input logic [7:0] b, input bit par_flip, input int nbits,
                            input int glitch_bit, input bit pop_on_stop);
    logic [10:0] bits;
    bits = {1'b1, (~^b) ^ par_flip, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk);
      ps2_data = bits[i];
      wait_neg(3);
      if (i == glitch_bit) begin
        ps2_clk = 1'b0;
        wait_neg(FL - 1);
        ps2_clk = 1'b1;
      end else begin
        wait_neg(3);
      end
      wait_neg(4);
      ps2_clk = 1'b0;
      for (int j = 1; j <= 8; j++) begin
        @(negedge clk);
        if (pop_on_stop && i == 10 && j == 7) rd_en = 1'b1;
        if (j == 8) rd_en = 1'b0;
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_neg(20);
  endtask

  task automatic pop(input string tag, input logic [7:0] exp);
    check(tag, {8'h0, rd_data}, {8'h0, exp});
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  initial begin
    wait_neg(3);
    check("rst_empty", {15'h0, empty}, 16'h1);
    check("rst_full", {15'h0, full}, 16'h0);
    check("rst_count", 16'(count), 16'h0);
    check("rst_rd_data", {8'h0, rd_data}, 16'h0);
    check("rst_overflow", {15'h0, overflow}, 16'h0);
    check("rst_frame_err", {15'h0, frame_err}, 16'h0);
    reset = 1'b0;
    wait_neg(10);

    // Single frame 0x1C.
    ferr_base = ferr_cnt;
    send_frame(8'h1C, 1'b0, 11, -1, 1'b0);
    check("f1c_empty", {15'h0, empty}, 16'h0);
    check("f1c_count", 16'(count), 16'h1);
    check("f1c_ferr", 16'(ferr_cnt - ferr_base), 16'h0);
    pop("f1c_data", 8'h1C);
    check("f1c_empty_after_pop", {15'h0, empty}, 16'h1);

    // Overfill with 0x01..0x09.
    ovf_base = ovf_cnt;
    for (int n = 1; n <= 8; n++) send_frame(8'(n), 1'b0, 11, -1, 1'b0);
    check("fill_full", {15'h0, full}, 16'h1);
    check("fill_count", 16'(count), 16'h8);
    check("fill_no_ovf", 16'(ovf_cnt - ovf_base), 16'h0);
    send_frame(8'h09, 1'b0, 11, -1, 1'b0);
    check("ovf_pulse", 16'(ovf_cnt - ovf_base), 16'h1);
    check("ovf_count", 16'(count), 16'h8);
    for (int n = 1; n <= 8; n++) pop("ovf_order", 8'(n));
    check("ovf_drained", {15'h0, empty}, 16'h1);

    // Inverted parity on 0x5A.
    ferr_base = ferr_cnt;
    send_frame(8'h5A, 1'b1, 11, -1, 1'b0);
`ifdef PS2_RX_PARITY_CHECK_EN
    check("par_ferr", 16'(ferr_cnt - ferr_base), 16'h1);
    check("par_empty", {15'h0, empty}, 16'h1);
`else
    check("par_ferr", 16'(ferr_cnt - ferr_base), 16'h0);
    check("par_count", 16'(count), 16'h1);
    pop("par_data", 8'h5A);
`endif

    // Truncated frame, timeout, then 0xF0.
    ferr_base = ferr_cnt;
    send_frame(8'hFF, 1'b0, 4, -1, 1'b0);
    check("tmo_no_early_err", 16'(ferr_cnt - ferr_base), 16'h0);
    wait_neg(TMO + 100);
    check("tmo_ferr", 16'(ferr_cnt - ferr_base), 16'h1);
    check("tmo_empty", {15'h0, empty}, 16'h1);
    send_frame(8'hF0, 1'b0, 11, -1, 1'b0);
    check("tmo_ferr_total", 16'(ferr_cnt - ferr_base), 16'h1);
    check("tmo_count", 16'(count), 16'h1);
    pop("tmo_data", 8'hF0);

    // Glitch in the high phase of data bit 2.
    ferr_base = ferr_cnt;
    send_frame(8'h33, 1'b0, 11, 3, 1'b0);
    check("glitch_ferr", 16'(ferr_cnt - ferr_base), 16'h0);
    check("glitch_count", 16'(count), 16'h1);
    pop("glitch_data", 8'h33);

    // Reset mid-frame with a byte already queued.
    send_frame(8'h42, 1'b0, 11, -1, 1'b0);
    send_frame(8'h00, 1'b0, 5, -1, 1'b0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("mid_rst_empty", {15'h0, empty}, 16'h1);
    check("mid_rst_count", 16'(count), 16'h0);
    check("mid_rst_rd_data", {8'h0, rd_data}, 16'h0);
    wait_neg(3);
    reset = 1'b0;
    wait_neg(10);
    ferr_base = ferr_cnt;
    send_frame(8'h24, 1'b0, 11, -1, 1'b0);
    check("post_rst_count", 16'(count), 16'h1);
    check("post_rst_ferr", 16'(ferr_cnt - ferr_base), 16'h0);
    pop("post_rst_data", 8'h24);

    // Full FIFO, pop coincident with the write of 0xAA.
    for (int n = 0; n < 8; n++) send_frame(8'h10 + 8'(n), 1'b0, 11, -1, 1'b0);
    check("simul_pre_full", {15'h0, full}, 16'h1);
    ovf_base = ovf_cnt;
    send_frame(8'hAA, 1'b0, 11, -1, 1'b1);
    check("simul_count", 16'(count), 16'h8);
    check("simul_no_ovf", 16'(ovf_cnt - ovf_base), 16'h0);
    for (int n = 1; n < 8; n++) pop("simul_order", 8'h10 + 8'(n));
    pop("simul_last", 8'hAA);
    check("simul_drained", {15'h0, empty}, 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
